// File: rtl/rf_wr_arbiter.sv
// Round-robin write-port arbiter in front of a shared WIDTH-bit register.
// One requester owns the port for up to MAX_BURST writes, then priority rotates.
module rf_wr_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   wdata,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    busy,
    output logic                    wr_pulse,
    output logic [WIDTH-1:0]        q
);

    localparam int unsigned PW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [CW-1:0]   cnt;

    logic [2*NREQ-1:0] req_rot2;
    logic [NREQ-1:0]   req_rot;
    logic [PW:0]       win_sum;
    logic [PW-1:0]     win;
    logic              win_found;
    logic [WIDTH-1:0]  wsel;
    logic              req_own;
    logic              rel;
    logic [PW-1:0]     ptr_nxt;

    // Rotate requests so bit 0 is the pointer position, take the first set bit, map back.
    always_comb begin
        req_rot2  = {req, req} >> ptr;
        req_rot   = req_rot2[NREQ-1:0];
        win_sum   = '0;
        win_found = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (!win_found && req_rot[j]) begin
                win_found = 1'b1;
                win_sum   = (PW+1)'(ptr) + (PW+1)'(j);
            end
        end
        if (win_sum >= (PW+1)'(NREQ)) begin
            win_sum = win_sum - (PW+1)'(NREQ);
        end
        win = win_sum[PW-1:0];
    end

    // Owner's data slice, owner's request, release condition and rotated pointer.
    always_comb begin
        wsel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner == PW'(i)) begin
                wsel = wdata[i*WIDTH +: WIDTH];
            end
        end
        req_own = |(req & gnt);
        rel     = !req_own || (cnt == CW'(MAX_BURST - 1));
        ptr_nxt = (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);
    end

    // Arbitration FSM, burst counting and the shared register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            owner    <= '0;
            busy     <= 1'b0;
            wr_pulse <= 1'b0;
            q        <= '0;
            ptr      <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wr_pulse <= 1'b0;
                    if (|req) begin
                        state <= GRANT;
                        gnt   <= NREQ'(1) << win;
                        owner <= win;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                GRANT: begin
                    wr_pulse <= req_own;
                    if (req_own) begin
                        q   <= wsel;
                        cnt <= cnt + CW'(1);
                    end
                    if (rel) begin
                        state <= IDLE;
                        gnt   <= '0;
                        owner <= '0;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        ptr   <= ptr_nxt;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
